// File: rtl/mmss_time_counter_pkg.sv
// mmss_time_counter_pkg
// Shared constants for the MM:SS BCD time counter: digit limits, the
// 59:59 rollover value, and the bit positions of each BCD field.
package mmss_time_counter_pkg;

  localparam int DIGIT_W = 4;

  localparam logic [3:0] UNITS_MAX = 4'd9;
  localparam logic [3:0] TENS_MAX  = 4'd5;

  localparam logic [15:0] ROLLOVER_BCD = 16'h5959;

  localparam int SEC_UNITS_LSB = 0;
  localparam int SEC_TENS_LSB  = 4;
  localparam int MIN_UNITS_LSB = 8;
  localparam int MIN_TENS_LSB  = 12;

  // True when every digit of an MMSS word is inside its legal range.
  function automatic logic bcdTimeValid(input logic [15:0] value);
    return (value[SEC_UNITS_LSB +: DIGIT_W] <= UNITS_MAX) &&
           (value[SEC_TENS_LSB  +: DIGIT_W] <= TENS_MAX)  &&
           (value[MIN_UNITS_LSB +: DIGIT_W] <= UNITS_MAX) &&
           (value[MIN_TENS_LSB  +: DIGIT_W] <= TENS_MAX);
  endfunction

endpackage

// File: rtl/mmss_time_counter_bcd_digit_counter.sv
// bcd_digit_counter
// One BCD digit with a configurable maximum. Increments on carry-in,
// wraps to 0 after MAX_VAL, and raises carry-out combinationally when the
// incoming carry will wrap it. A load overwrites the digit outright.
module bcd_digit_counter
  import mmss_time_counter_pkg::*;
#(
  parameter logic [3:0] MAX_VAL = UNITS_MAX
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       load_i,
  input  logic [3:0] loadValue_i,
  input  logic       carry_i,
  output logic [3:0] digit_o,
  output logic       carry_o
);

  logic [3:0] digit_q;
  logic [3:0] digit_d;

  // Next digit value: load wins, otherwise step on carry with wrap at MAX_VAL.
  always_comb begin
    digit_d = digit_q;
    if (load_i) begin
      digit_d = loadValue_i;
    end else if (carry_i) begin
      digit_d = (digit_q == MAX_VAL) ? 4'd0 : digit_q + 4'd1;
    end
  end

  // Digit register with synchronous reset to zero.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      digit_q <= 4'd0;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign digit_o = digit_q;
  assign carry_o = carry_i && (digit_q == MAX_VAL);

endmodule

// File: rtl/mmss_time_counter.sv
// mmss_time_counter
// MM:SS BCD time counter driven by a prescaler that produces one tick every
// CLK_DIV clock cycles. Supports validated loads and single-cycle status
// pulses. Optional alarm comparator is compiled in with ALARM_MATCH_EN.
module mmss_time_counter
  import mmss_time_counter_pkg::*;
#(
  parameter int CLK_DIV = 100000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic        load,
  input  logic [15:0] load_bcd,
  input  logic [15:0] alarm_bcd,
  output logic [15:0] time_bcd,
  output logic        sec_pulse,
  output logic        wrap,
  output logic        load_err,
  output logic        alarm_hit
);

  localparam int PRE_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_DIV - 1);

  logic [PRE_W-1:0] prescaler_q;
  logic [PRE_W-1:0] prescaler_d;
  logic             secPulse_q;
  logic             secPulse_d;
  logic             wrap_q;
  logic             wrap_d;
  logic             loadErr_q;
  logic             loadErr_d;

  logic tick;
  logic loadOk;
  logic incr;
  logic carrySecTens;
  logic carryMinUnits;
  logic carryMinTens;
  logic unusedTopCarry;

  assign tick   = run && (prescaler_q == PRE_LAST);
  assign loadOk = load && bcdTimeValid(load_bcd);
  assign incr   = tick && !loadOk;

  // Prescaler: cleared by a valid load, frozen when not running.
  always_comb begin
    prescaler_d = prescaler_q;
    if (loadOk) begin
      prescaler_d = '0;
    end else if (run) begin
      prescaler_d = tick ? '0 : prescaler_q + PRE_W'(1);
    end
  end

  // Prescaler register.
  always_ff @(posedge clk) begin
    if (reset) begin
      prescaler_q <= '0;
    end else begin
      prescaler_q <= prescaler_d;
    end
  end

  bcd_digit_counter #(.MAX_VAL(UNITS_MAX)) u_secUnits (
    .clk_i(clk), .reset_i(reset), .load_i(loadOk),
    .loadValue_i(load_bcd[SEC_UNITS_LSB +: DIGIT_W]), .carry_i(incr),
    .digit_o(time_bcd[SEC_UNITS_LSB +: DIGIT_W]), .carry_o(carrySecTens)
  );

  bcd_digit_counter #(.MAX_VAL(TENS_MAX)) u_secTens (
    .clk_i(clk), .reset_i(reset), .load_i(loadOk),
    .loadValue_i(load_bcd[SEC_TENS_LSB +: DIGIT_W]), .carry_i(carrySecTens),
    .digit_o(time_bcd[SEC_TENS_LSB +: DIGIT_W]), .carry_o(carryMinUnits)
  );

  bcd_digit_counter #(.MAX_VAL(UNITS_MAX)) u_minUnits (
    .clk_i(clk), .reset_i(reset), .load_i(loadOk),
    .loadValue_i(load_bcd[MIN_UNITS_LSB +: DIGIT_W]), .carry_i(carryMinUnits),
    .digit_o(time_bcd[MIN_UNITS_LSB +: DIGIT_W]), .carry_o(carryMinTens)
  );

  bcd_digit_counter #(.MAX_VAL(TENS_MAX)) u_minTens (
    .clk_i(clk), .reset_i(reset), .load_i(loadOk),
    .loadValue_i(load_bcd[MIN_TENS_LSB +: DIGIT_W]), .carry_i(carryMinTens),
    .digit_o(time_bcd[MIN_TENS_LSB +: DIGIT_W]), .carry_o(unusedTopCarry)
  );

  // Status pulses are derived from this cycle's decisions and land with the
  // updated time one cycle later.
  always_comb begin
    secPulse_d = incr;
    wrap_d     = incr && (time_bcd == ROLLOVER_BCD);
    loadErr_d  = load && !loadOk;
  end

  // Status pulse registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      secPulse_q <= 1'b0;
      wrap_q     <= 1'b0;
      loadErr_q  <= 1'b0;
    end else begin
      secPulse_q <= secPulse_d;
      wrap_q     <= wrap_d;
      loadErr_q  <= loadErr_d;
    end
  end

  assign sec_pulse = secPulse_q;
  assign wrap      = wrap_q;
  assign load_err  = loadErr_q;

`ifdef ALARM_MATCH_EN
  logic update_q;
  logic alarmHit_q;

  // Compare only in the cycle right after the time register was written, so
  // a held matching time produces a single pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      update_q   <= 1'b0;
      alarmHit_q <= 1'b0;
    end else begin
      update_q   <= incr || loadOk;
      alarmHit_q <= update_q && (time_bcd == alarm_bcd);
    end
  end

  assign alarm_hit = alarmHit_q;
`else
  logic unusedAlarmBcd;
  assign unusedAlarmBcd = ^alarm_bcd;
  assign alarm_hit      = 1'b0;
`endif

endmodule

// File: tb/tb_mmss_time_counter.sv
// tb_mmss_time_counter
// Scoreboard bench: stimulus pushes per-cycle expected outputs from a
// decimal reference model, a monitor pops and compares after each edge.
module tb_mmss_time_counter;

  localparam int CLK_DIV = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        run;
  logic        load;
  logic [15:0] load_bcd;
  logic [15:0] alarm_bcd;
  logic [15:0] time_bcd;
  logic        sec_pulse;
  logic        wrap;
  logic        load_err;
  logic        alarm_hit;

  typedef struct packed {
    logic [15:0] timeBcd;
    logic        sec;
    logic        wrp;
    logic        err;
    logic        alarm;
  } expT;

  expT expQ[$];
  int  checks   = 0;
  int  failures = 0;

  int mMin = 0;
  int mSec = 0;
  int mPre = 0;
  bit mUpd = 1'b0;

  mmss_time_counter #(.CLK_DIV(CLK_DIV)) dut (
    .clk(clk), .reset(reset), .run(run), .load(load),
    .load_bcd(load_bcd), .alarm_bcd(alarm_bcd), .time_bcd(time_bcd),
    .sec_pulse(sec_pulse), .wrap(wrap), .load_err(load_err),
    .alarm_hit(alarm_hit)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  function automatic logic [15:0] toBcd(input int m, input int s);
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  function automatic bit digitsLegal(input logic [15:0] v);
    return (int'(v[15:12]) < 6) && (int'(v[11:8]) < 10) &&
           (int'(v[7:4]) < 6) && (int'(v[3:0]) < 10);
  endfunction

  task automatic checkOutput(input string name, input logic [15:0] act,
                             input logic [15:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  // Drive one cycle of inputs and push what the outputs must look like after
  // the following rising edge.
  task automatic applyStimulus(input logic r, input logic ru, input logic ld,
                               input logic [15:0] v);
    expT e;
    bit  tick;
    int  total;
    @(negedge clk);
    reset    = r;
    run      = ru;
    load     = ld;
    load_bcd = v;
    e = '0;
`ifdef ALARM_MATCH_EN
    e.alarm = mUpd && (toBcd(mMin, mSec) == alarm_bcd);
`endif
    if (r) begin
      mMin = 0; mSec = 0; mPre = 0; mUpd = 1'b0;
      e.alarm = 1'b0;
    end else begin
      tick = ru && (mPre == CLK_DIV - 1);
      mUpd = 1'b0;
      if (ld && digitsLegal(v)) begin
        mMin = int'(v[15:12]) * 10 + int'(v[11:8]);
        mSec = int'(v[7:4]) * 10 + int'(v[3:0]);
        mPre = 0;
        mUpd = 1'b1;
      end else begin
        if (ld) e.err = 1'b1;
        if (tick) begin
          total = mMin * 60 + mSec + 1;
          if (total == 3600) begin
            e.wrp = 1'b1;
            total = 0;
          end
          mMin  = total / 60;
          mSec  = total % 60;
          e.sec = 1'b1;
          mUpd  = 1'b1;
        end
        if (ru) mPre = tick ? 0 : mPre + 1;
      end
    end
    e.timeBcd = toBcd(mMin, mSec);
    expQ.push_back(e);
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
  endtask

  // Monitor: one expected entry per cycle, checked just after the edge.
  initial begin : monitor
    expT e;
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("time_bcd",  time_bcd,          e.timeBcd);
        checkOutput("sec_pulse", {15'd0, sec_pulse}, {15'd0, e.sec});
        checkOutput("wrap",      {15'd0, wrap},      {15'd0, e.wrp});
        checkOutput("load_err",  {15'd0, load_err},  {15'd0, e.err});
        checkOutput("alarm_hit", {15'd0, alarm_hit}, {15'd0, e.alarm});
      end
    end
  end

  // Directed scenarios.
  initial begin : stimulus
    int drain;
    reset = 1'b1; run = 1'b0; load = 1'b0;
    load_bcd = 16'h0000; alarm_bcd = 16'h0003;

    // Reset, then free-run through the 0009 -> 0010 carry.
    repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
    runCycles(44);

    // Rollover 5958 -> 5959 -> 0000 with wrap.
    applyStimulus(1'b0, 1'b1, 1'b1, 16'h5958);
    runCycles(9);

    // Minutes carry 0059 -> 0100.
    applyStimulus(1'b0, 1'b1, 1'b1, 16'h0058);
    runCycles(9);

    // Load validation, including rejected loads while ticking.
    applyStimulus(1'b0, 1'b1, 1'b1, 16'h1234);
    runCycles(2);
    applyStimulus(1'b0, 1'b1, 1'b1, 16'h0960);
    runCycles(1);
    applyStimulus(1'b0, 1'b1, 1'b1, 16'h6000);
    runCycles(5);

    // Load coinciding with a tick wins; next tick is a full period later.
    while (mPre != CLK_DIV - 1) applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
    applyStimulus(1'b0, 1'b1, 1'b1, 16'h0500);
    runCycles(8);

    // Frozen for 10 cycles, then a load while frozen, then resume.
    runCycles(2);
    repeat (10) applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0030);
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
    runCycles(5);

    // Load held for several cycles behaves as independent loads.
    applyStimulus(1'b0, 1'b1, 1'b1, 16'h0111);
    applyStimulus(1'b0, 1'b1, 1'b1, 16'h0222);
    applyStimulus(1'b0, 1'b1, 1'b1, 16'h0999);
    runCycles(4);

    // Reset mid-count at 0417 leaves nothing pending.
    applyStimulus(1'b0, 1'b1, 1'b1, 16'h0416);
    runCycles(6);
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000);
    runCycles(3);

    // Alarm sequence from 0000 with alarm at 0003, then reload 0003.
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
    runCycles(16);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0003);
    repeat (4) applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);

    drain = 0;
    while (expQ.size() > 0 && drain < 10) begin
      @(posedge clk);
      drain++;
    end
    #2;
    if (expQ.size() > 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL drain: got %0d pending expected 0", expQ.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
